wb_select_stage: RTL and testbench

- Registered writeback stage for the RISC-V core; successor to the combinational writeback data selector.
- Selects the register-file write value from five sources: ALU result, formatted load data, PC+step, U-type immediate, and CSR read data.
- Performs load byte/halfword extraction and sign/zero extension, and flags illegal selects and misaligned loads.
- Presents the result one cycle later with valid, stall and flush control; sits between the MEM stage and the register file.

---
 rtl/wb_select_stage_pkg.sv | 18 +
 rtl/wb_select_stage_if.sv | 49 ++++
 rtl/wb_select_stage_load_formatter.sv | 46 ++++
 rtl/wb_select_stage.sv | 84 ++++++++
 tb/tb_wb_select_stage.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_select_stage_pkg.sv
// Shared encodings for the writeback select stage: source selects and load funct3 codes.
package wb_pkg;

  typedef enum logic [2:0] {
    WB_SEL_ALU  = 3'b000,
    WB_SEL_LOAD = 3'b001,
    WB_SEL_PC   = 3'b010,
    WB_SEL_IMM  = 3'b011,
    WB_SEL_CSR  = 3'b100
  } wb_sel_e;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

endpackage

// File: rtl/wb_select_stage_if.sv
// MEM-to-writeback bus; the stage uses the slave modport, the MEM side the master modport.
// o_retire_cnt exists only when WB_RETIRE_CNT_EN is defined.
interface wb_select_stage_if #(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 5
);

  logic               i_valid;
  logic               i_stall;
  logic               i_flush;
  logic [2:0]         i_sel;
  logic [2:0]         i_funct3;
  logic [1:0]         i_addr_lo;
  logic [WIDTH-1:0]   i_alu_result;
  logic [WIDTH-1:0]   i_mem_data;
  logic [WIDTH-1:0]   i_pc;
  logic [WIDTH-1:0]   i_imm;
  logic [WIDTH-1:0]   i_csr_data;
  logic [RD_BITS-1:0] i_rd;
  logic               i_regwrite;

  logic               o_valid;
  logic               o_we;
  logic [RD_BITS-1:0] o_rd;
  logic [WIDTH-1:0]   o_data;
  logic               o_illegal;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]        o_retire_cnt;
`endif

  modport master (
`ifdef WB_RETIRE_CNT_EN
    input  o_retire_cnt,
`endif
    output i_valid, i_stall, i_flush, i_sel, i_funct3, i_addr_lo,
    output i_alu_result, i_mem_data, i_pc, i_imm, i_csr_data, i_rd, i_regwrite,
    input  o_valid, o_we, o_rd, o_data, o_illegal
  );

  modport slave (
`ifdef WB_RETIRE_CNT_EN
    output o_retire_cnt,
`endif
    input  i_valid, i_stall, i_flush, i_sel, i_funct3, i_addr_lo,
    input  i_alu_result, i_mem_data, i_pc, i_imm, i_csr_data, i_rd, i_regwrite,
    output o_valid, o_we, o_rd, o_data, o_illegal
  );

endinterface

// File: rtl/wb_select_stage_load_formatter.sv
// Combinational load extraction: picks the byte/half/word at the load offset, extends it,
// and flags misaligned or unknown load types (data forced to zero when flagged).
module load_formatter
  import wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] data,
  output logic             illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;

  assign word_sel = mem_data[31:0];
  assign byte_sel = word_sel[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? word_sel[31:16] : word_sel[15:0];

  // Signed casts widen by sign extension; plain casts zero-extend.
  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (funct3)
      LD_B:  data = WIDTH'($signed(byte_sel));
      LD_BU: data = WIDTH'(byte_sel);
      LD_H: begin
        if (addr_lo[0]) illegal = 1'b1;
        else            data    = WIDTH'($signed(half_sel));
      end
      LD_HU: begin
        if (addr_lo[0]) illegal = 1'b1;
        else            data    = WIDTH'(half_sel);
      end
      LD_W: begin
        if (addr_lo != 2'b00) illegal = 1'b1;
        else                  data    = WIDTH'($signed(word_sel));
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// Registered writeback stage: selects the register-file write value and presents it one cycle later.
// Define WB_RETIRE_CNT_EN to add a 64-bit retired-instruction counter (o_retire_cnt).
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PC_STEP = 4,
  parameter int RD_BITS = 5
) (
  input logic        i_clk,
  input logic        i_rst,
  wb_select_stage_if.slave bus
);

  logic [WIDTH-1:0] ld_data;
  logic             ld_illegal;
  logic [WIDTH-1:0] sel_data;
  logic             sel_illegal;
  logic             next_we;

  load_formatter #(.WIDTH(WIDTH)) u_load_formatter (
    .funct3   (bus.i_funct3),
    .addr_lo  (bus.i_addr_lo),
    .mem_data (bus.i_mem_data),
    .data     (ld_data),
    .illegal  (ld_illegal)
  );

  // Every select path assigns sel_data, so illegal cases write zero rather than stale data.
  always_comb begin
    sel_data    = '0;
    sel_illegal = 1'b0;
    case (bus.i_sel)
      WB_SEL_ALU:  sel_data = bus.i_alu_result;
      WB_SEL_LOAD: begin
        sel_data    = ld_data;
        sel_illegal = ld_illegal;
      end
      WB_SEL_PC:   sel_data = bus.i_pc + WIDTH'(PC_STEP);
      WB_SEL_IMM:  sel_data = bus.i_imm;
      WB_SEL_CSR:  sel_data = bus.i_csr_data;
      default:     sel_illegal = 1'b1;
    endcase
    if (sel_illegal) sel_data = '0;
  end

  assign next_we = bus.i_valid & bus.i_regwrite & (bus.i_rd != '0) & ~sel_illegal;

  // Flush only clears the control bits; data and rd keep their last value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_valid   <= 1'b0;
      bus.o_we      <= 1'b0;
      bus.o_rd      <= '0;
      bus.o_data    <= '0;
      bus.o_illegal <= 1'b0;
    end else if (bus.i_flush) begin
      bus.o_valid   <= 1'b0;
      bus.o_we      <= 1'b0;
      bus.o_illegal <= 1'b0;
    end else if (!bus.i_stall) begin
      bus.o_valid   <= bus.i_valid;
      bus.o_we      <= next_we;
      bus.o_rd      <= bus.i_rd;
      bus.o_data    <= sel_data;
      bus.o_illegal <= bus.i_valid & sel_illegal;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      retire_cnt <= '0;
    end else if (!bus.i_flush && !bus.i_stall && bus.i_valid && !sel_illegal) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end

  assign bus.o_retire_cnt = retire_cnt;
`endif

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed self-checking bench for wb_select_stage with hand-computed expectations.
// Checks o_retire_cnt as well when built with WB_RETIRE_CNT_EN.
module tb_wb_select_stage;
  import wb_pkg::*;

  logic i_clk;
  logic i_rst;
  int   check_count;
  int   fail_count;

  wb_select_stage_if #(.WIDTH(32), .RD_BITS(5)) bus ();

  wb_select_stage #(.WIDTH(32), .PC_STEP(4), .RD_BITS(5)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic valid, input logic we, input logic [4:0] rd,
                          input logic [31:0] data, input logic illegal);
    checkOutput({tag, ".valid"},   64'(bus.o_valid),   64'(valid));
    checkOutput({tag, ".we"},      64'(bus.o_we),      64'(we));
    checkOutput({tag, ".rd"},      64'(bus.o_rd),      64'(rd));
    checkOutput({tag, ".data"},    64'(bus.o_data),    64'(data));
    checkOutput({tag, ".illegal"}, 64'(bus.o_illegal), 64'(illegal));
  endtask

  // Drives one instruction with stall/flush low and returns 1ns after the capturing edge.
  task automatic applyStimulus(input logic valid, input logic [2:0] sel, input logic [2:0] funct3,
                               input logic [1:0] addr_lo, input logic [4:0] rd, input logic regwrite);
    bus.i_valid    = valid;
    bus.i_sel      = sel;
    bus.i_funct3   = funct3;
    bus.i_addr_lo  = addr_lo;
    bus.i_rd       = rd;
    bus.i_regwrite = regwrite;
    bus.i_stall    = 1'b0;
    bus.i_flush    = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    check_count      = 0;
    fail_count       = 0;
    i_clk            = 1'b0;
    i_rst            = 1'b1;
    bus.i_valid      = 1'b0;
    bus.i_stall      = 1'b0;
    bus.i_flush      = 1'b0;
    bus.i_sel        = 3'b000;
    bus.i_funct3     = 3'b000;
    bus.i_addr_lo    = 2'b00;
    bus.i_alu_result = 32'hA1A1_0001;
    bus.i_mem_data   = 32'hB2B2_0002;
    bus.i_pc         = 32'h0000_0100;
    bus.i_imm        = 32'hC3C3_0000;
    bus.i_csr_data   = 32'hD4D4_0004;
    bus.i_rd         = 5'd0;
    bus.i_regwrite   = 1'b0;

    repeat (2) @(posedge i_clk);
    #1;
    checkAll("reset", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
`ifdef WB_RETIRE_CNT_EN
    checkOutput("reset.retire", bus.o_retire_cnt, 64'd0);
`endif
    i_rst = 1'b0;

    bus.i_alu_result = 32'h1111_2222;
    applyStimulus(1'b1, WB_SEL_ALU, 3'b000, 2'd0, 5'd3, 1'b1);
    checkAll("alu", 1'b1, 1'b1, 5'd3, 32'h1111_2222, 1'b0);

    bus.i_mem_data = 32'h1280_3456;
    applyStimulus(1'b1, WB_SEL_LOAD, LD_B, 2'd2, 5'd5, 1'b1);
    checkAll("lb", 1'b1, 1'b1, 5'd5, 32'hFFFF_FF80, 1'b0);
    applyStimulus(1'b1, WB_SEL_LOAD, LD_BU, 2'd2, 5'd5, 1'b1);
    checkAll("lbu", 1'b1, 1'b1, 5'd5, 32'h0000_0080, 1'b0);
    applyStimulus(1'b1, WB_SEL_LOAD, LD_B, 2'd0, 5'd6, 1'b1);
    checkAll("lb_off0", 1'b1, 1'b1, 5'd6, 32'h0000_0056, 1'b0);

    applyStimulus(1'b1, WB_SEL_LOAD, LD_H, 2'd1, 5'd5, 1'b1);
    checkAll("lh_misaligned", 1'b1, 1'b0, 5'd5, 32'h0, 1'b1);

    bus.i_mem_data = 32'h8001_0000;
    applyStimulus(1'b1, WB_SEL_LOAD, LD_HU, 2'd2, 5'd4, 1'b1);
    checkAll("lhu", 1'b1, 1'b1, 5'd4, 32'h0000_8001, 1'b0);
    applyStimulus(1'b1, WB_SEL_LOAD, LD_H, 2'd2, 5'd4, 1'b1);
    checkAll("lh", 1'b1, 1'b1, 5'd4, 32'hFFFF_8001, 1'b0);

    bus.i_mem_data = 32'hCAFE_F00D;
    applyStimulus(1'b1, WB_SEL_LOAD, LD_W, 2'd0, 5'd8, 1'b1);
    checkAll("lw", 1'b1, 1'b1, 5'd8, 32'hCAFE_F00D, 1'b0);
    applyStimulus(1'b1, WB_SEL_LOAD, LD_W, 2'd2, 5'd8, 1'b1);
    checkAll("lw_misaligned", 1'b1, 1'b0, 5'd8, 32'h0, 1'b1);
    applyStimulus(1'b1, WB_SEL_LOAD, 3'b011, 2'd0, 5'd8, 1'b1);
    checkAll("ld_bad_funct3", 1'b1, 1'b0, 5'd8, 32'h0, 1'b1);

    bus.i_pc = 32'hFFFF_FFFC;
    applyStimulus(1'b1, WB_SEL_PC, 3'b000, 2'd0, 5'd1, 1'b1);
    checkAll("jal_wrap", 1'b1, 1'b1, 5'd1, 32'h0, 1'b0);
    applyStimulus(1'b1, WB_SEL_PC, 3'b000, 2'd0, 5'd0, 1'b1);
    checkAll("jal_x0", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    bus.i_pc = 32'h0000_0100;
    applyStimulus(1'b1, WB_SEL_PC, 3'b000, 2'd0, 5'd1, 1'b1);
    checkAll("jal", 1'b1, 1'b1, 5'd1, 32'h0000_0104, 1'b0);

    applyStimulus(1'b1, WB_SEL_IMM, 3'b000, 2'd0, 5'd10, 1'b1);
    checkAll("lui", 1'b1, 1'b1, 5'd10, 32'hC3C3_0000, 1'b0);
    applyStimulus(1'b1, WB_SEL_CSR, 3'b000, 2'd0, 5'd11, 1'b1);
    checkAll("csr", 1'b1, 1'b1, 5'd11, 32'hD4D4_0004, 1'b0);
    applyStimulus(1'b1, WB_SEL_CSR, 3'b000, 2'd0, 5'd11, 1'b0);
    checkAll("no_regwrite", 1'b1, 1'b0, 5'd11, 32'hD4D4_0004, 1'b0);

    applyStimulus(1'b1, 3'b111, 3'b000, 2'd0, 5'd12, 1'b1);
    checkAll("sel_111", 1'b1, 1'b0, 5'd12, 32'h0, 1'b1);
    applyStimulus(1'b1, 3'b101, 3'b000, 2'd0, 5'd12, 1'b1);
    checkAll("sel_101", 1'b1, 1'b0, 5'd12, 32'h0, 1'b1);

    // A stall with a legal instruction waiting must keep the captured illegal flag.
    bus.i_stall = 1'b1;
    bus.i_sel   = WB_SEL_ALU;
    @(posedge i_clk);
    #1;
    checkAll("stall_illegal", 1'b1, 1'b0, 5'd12, 32'h0, 1'b1);

    bus.i_alu_result = 32'h5555_AAAA;
    applyStimulus(1'b0, WB_SEL_ALU, 3'b000, 2'd0, 5'd9, 1'b1);
    checkAll("bubble", 1'b0, 1'b0, 5'd9, 32'h5555_AAAA, 1'b0);
    applyStimulus(1'b0, 3'b110, 3'b000, 2'd0, 5'd9, 1'b1);
    checkAll("bubble_reserved", 1'b0, 1'b0, 5'd9, 32'h0, 1'b0);

    bus.i_alu_result = 32'hDEAD_BEEF;
    applyStimulus(1'b1, WB_SEL_ALU, 3'b000, 2'd0, 5'd7, 1'b1);
    checkAll("pre_stall", 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
    bus.i_alu_result = 32'h0000_0000;
    bus.i_rd         = 5'd2;
    for (int i = 0; i < 3; i++) begin
      bus.i_stall = 1'b1;
      @(posedge i_clk);
      #1;
      checkAll($sformatf("stall%0d", i), 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
    end
    bus.i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("flush_stall.valid",   64'(bus.o_valid),   64'd0);
    checkOutput("flush_stall.we",      64'(bus.o_we),      64'd0);
    checkOutput("flush_stall.illegal", 64'(bus.o_illegal), 64'd0);
    bus.i_flush = 1'b0;
    bus.i_stall = 1'b0;

    // Reset mid-operation must clear outputs without waiting for a clock edge.
    bus.i_alu_result = 32'h0BAD_F00D;
    applyStimulus(1'b1, WB_SEL_ALU, 3'b000, 2'd0, 5'd13, 1'b1);
    checkAll("pre_reset", 1'b1, 1'b1, 5'd13, 32'h0BAD_F00D, 1'b0);
    #2;
    i_rst = 1'b1;
    #1;
    checkAll("async_reset", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
`ifdef WB_RETIRE_CNT_EN
    checkOutput("async_reset.retire", bus.o_retire_cnt, 64'd0);
`endif
    @(negedge i_clk);
    i_rst = 1'b0;

    bus.i_alu_result = 32'h0000_0042;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, WB_SEL_ALU, 3'b000, 2'd0, 5'd14, 1'b1);
    end
    checkAll("retire_legal", 1'b1, 1'b1, 5'd14, 32'h0000_0042, 1'b0);
    applyStimulus(1'b1, 3'b111, 3'b000, 2'd0, 5'd14, 1'b1);
    bus.i_flush = 1'b1;
    bus.i_sel   = WB_SEL_ALU;
    @(posedge i_clk);
    #1;
    checkOutput("flush.valid", 64'(bus.o_valid), 64'd0);
    bus.i_flush = 1'b0;
    bus.i_stall = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_stall = 1'b0;
    applyStimulus(1'b0, WB_SEL_ALU, 3'b000, 2'd0, 5'd14, 1'b1);
`ifdef WB_RETIRE_CNT_EN
    checkOutput("retire_cnt", bus.o_retire_cnt, 64'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
